// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the scanline row RAM path.
// Consumed by ppu_rowram_writer.
package ppu_pkg;

  localparam int ROW_W         = 320;
  localparam int ROWS          = 240;
  localparam int ROWRAM_ADDR_W = 9;

  typedef struct packed {
    logic [5:0] palette;
    logic [3:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    START,
    FILL,
    DONE
  } rowwr_state_t;

endpackage

// File: rtl/ppu_rowram_writer.sv
// Row RAM write front end: fills the back bank one scanline at a time.
// Optional ROWRAM_UNDERRUN_CNT_EN adds a saturating underrun counter.
module ppu_rowram_writer #(
  parameter int ROW_W  = 320,
  parameter int ROWS   = 240,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rowram_swap,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_data,
  output logic              row_start,
  output logic              frame_start,
  output logic [7:0]        row_num,
  output logic              rowram_wren,
  output logic [ADDR_W-1:0] rowram_wraddr,
  output logic [9:0]        rowram_wrdata,
  output logic              rowram_wrbank,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);
  import ppu_pkg::*;

  rowwr_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        row_q, row_d;
  logic              bank_q, bank_d;
  logic              rs_q, rs_d;
  logic              fs_q, fs_d;
  logic              ur_q, ur_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  pixel_t            data_q, data_d;
  logic              adv;
  logic              last;

  assign pix_ready = (state_q == FILL) && !rowram_swap;
  assign last      = wr_ptr_q == ADDR_W'(ROW_W - 1);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    row_d    = row_q;
    bank_d   = bank_q;
    rs_d     = 1'b0;
    fs_d     = 1'b0;
    ur_d     = 1'b0;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    adv      = 1'b0;
    unique case (state_q)
      START: begin
        rs_d    = 1'b1;
        fs_d    = row_q == 8'd0;
        state_d = FILL;
      end
      FILL: begin
        if (rowram_swap) begin
          ur_d     = 1'b1;
          adv      = 1'b1;
          wr_ptr_d = '0;
        end else if (pix_valid) begin
          wren_d = 1'b1;
          addr_d = wr_ptr_q;
          data_d = pixel_t'(pix_data);
          if (last) begin
            wr_ptr_d = '0;
            state_d  = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      DONE: adv = rowram_swap;
      default: state_d = START;
    endcase
    // Swap honoured in FILL or DONE: flip banks, move to next row
    if (adv) begin
      bank_d  = ~bank_q;
      row_d   = (row_q == 8'(ROWS - 1)) ? 8'd0 : row_q + 8'd1;
      state_d = START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= START;
      wr_ptr_q <= '0;
      row_q    <= '0;
      bank_q   <= 1'b1;
      rs_q     <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      row_q    <= row_d;
      bank_q   <= bank_d;
      rs_q     <= rs_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

`ifdef ROWRAM_UNDERRUN_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (ur_d && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = '0;
`endif

  assign row_start     = rs_q;
  assign frame_start   = fs_q;
  assign row_num       = row_q;
  assign rowram_wren   = wren_q;
  assign rowram_wraddr = addr_q;
  assign rowram_wrdata = data_q;
  assign rowram_wrbank = bank_q;
  assign underrun      = ur_q;

endmodule

// File: doc/ppu_rowram_writer.md
Name: ppu_rowram_writer

Overview:
Write-side front end of the PPU scanline row RAM. It accepts a stream of 10-bit palette-indexed pixels from the PPU compositor and writes one scanline of pixels into the back bank of the double-buffered row RAM. It then waits for the video output's row swap, flips banks and requests the next row. The video output reads the front bank; this block only ever writes the opposite bank.

Parameters:
ROW_W, 320, pixels per scanline (max 512).
ROWS, 240, scanlines per frame.
ADDR_W, 9, row RAM address width.

Ports:
clk  input  1  system clock
rst_n  input  1  reset
rowram_swap  input  1  one-cycle swap pulse from video side, already synchronous to clk
pix_valid  input  1  pixel stream valid
pix_ready  output  1  pixel stream ready
pix_data  input  10  palette index {palette[5:0], colour[3:0]}
row_start  output  1  one-cycle pulse: compositor should begin row row_num
frame_start  output  1  one-cycle pulse coincident with row_start when row_num==0
row_num  output  8  row currently being filled
rowram_wren  output  1  row RAM write enable
rowram_wraddr  output  ADDR_W  write address within bank
rowram_wrdata  output  10  write data
rowram_wrbank  output  1  bank being written; reader uses ~rowram_wrbank
underrun  output  1  one-cycle pulse: swap arrived before row complete
underrun_cnt  output  16  saturating underrun count (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous, active-low (clk, rst_n).
- Reset values:
  - state=START, wr_ptr=0, row_num=0, rowram_wrbank=1.
  - All pulses, rowram_wren, rowram_wraddr, rowram_wrdata and underrun_cnt are 0.
- States: START, FILL, DONE.
- START:
  - Lasts exactly one cycle.
  - Registers row_start=1; frame_start=1 if row_num==0.
  - Goes to FILL. rowram_swap is ignored in this state.
- FILL:
  - pix_ready = (state==FILL) && !rowram_swap. This is the only combinational output.
  - Handshake when pix_valid && pix_ready. The next cycle shows rowram_wren=1, rowram_wraddr=wr_ptr, rowram_wrdata=pix_data. Write latency is 1.
  - wr_ptr increments per handshake.
  - On the handshake with wr_ptr==ROW_W-1: wr_ptr←0, go to DONE.
- DONE:
  - pix_ready=0.
  - On rowram_swap: rowram_wrbank toggles, row_num increments (ROWS-1 wraps to 0), go to START.
- Swap in FILL (underrun):
  - Same bank, row_num and START actions as in DONE.
  - underrun pulses the next cycle. wr_ptr←0. Remaining pixels of the aborted row are never written.
  - No pixel is accepted in the swap cycle, so a swap coincident with the final pixel is an underrun.
- Swap arriving during the START cycle is dropped. The reader re-shows the previous bank.
- Bank toggle is visible the cycle after the swap. Any write still in flight (wren registered before the toggle) completes to the old bank address, with the bank sampled at handshake.
- row_start and frame_start are single-cycle pulses; they never overlap a write to a new-row address.
- Asynchronous reset mid-row abandons the row; the bank returns to 1 and row_num to 0.

Optional Feature:
ROWRAM_UNDERRUN_CNT_EN
- Defined: underrun_cnt increments on each underrun pulse and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: underrun_cnt is tied to 0 and no counter flops are synthesised. The underrun pulse is unaffected.

Decomposition:
- Shared package ppu_pkg holds:
  - ROW_W, ROWS and ROWRAM_ADDR_W constants.
  - pixel_t typedef: packed struct {logic [5:0] palette; logic [3:0] colour}.
  - rowwr_state_t enum {START, FILL, DONE}.
- No sub-module is natural. The state machine, pointer and bank logic are one tightly coupled unit.
- The optional counter stays inline, guarded by the macro.

Test Plan (ROW_W=8, ROWS=4 unless noted):
1. Reset release, pix_valid held 1, data 10'h001..10'h008:
   - row_start and frame_start pulse with row_num=0.
   - Eight writes to bank 1, addresses 0..7, data 1..8.
   - pix_ready low after the 8th handshake. No further writes.
2. Full rows with a rowram_swap after each row completes:
   - Bank sequence 1,0,1,0,1.
   - row_num 0,1,2,3,0.
   - frame_start only on row_num 0 rows. underrun never pulses.
3. Swap after 5 of 8 pixels:
   - underrun pulses once. Bank toggles and row_num increments.
   - The next row's first write goes to address 0. With macro defined, underrun_cnt=1.
4. Swap on the same cycle pix_valid presents the 8th pixel:
   - pix_ready=0 that cycle and the pixel is not written.
   - underrun pulses and the next row restarts at address 0.
5. Swap asserted during the START cycle:
   - Ignored: no bank toggle and no underrun.
   - The row fills normally and the next swap is honoured.
6. Assert rst_n low mid-row (wr_ptr=3, bank=0, row_num=2):
   - All outputs return to reset values immediately.
   - After release, row 0 is written into bank 1 from address 0.
